// File: rtl/vpu_reduction_seq.sv
// vpu_reduction_seq: runs one full-vector FP sum / FP max reduction.
// Reads EXEC_CNT chunks from the VRF, issues each to the reduction unit,
// and writes the final scalar back over a valid/ready handshake.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid_i/req_ready_o       request handshake
//   req_op_i                      bit0 fp_sum, bit1 fp_max (one-hot)
//   req_src_i/req_dst_i           chunk 0 address / result address
//   rd_en_o/rd_addr_o/rd_data_i   VRF read port (data 1 cycle after en)
//   red_start_o                   start pulse to the reduction unit
//   red_sum_o/red_max_o           op select, held for the whole op
//   red_operand_o                 registered chunk operand
//   red_done_i/red_dout_i         unit done pulse and scalar result
//   wb_valid_o/wb_ready_i         write-back handshake
//   wb_addr_o/wb_data_o           write-back address and data
//   busy_o                        high whenever not IDLE
//   err_o                         one-cycle pulse: illegal op or timeout
module vpu_reduction_seq #(
    parameter int EXEC_CNT        = 4,
    parameter int DWIDTH_PER_EXEC = 512,
    parameter int OPERAND_WIDTH   = 16,
    parameter int ADDR_WIDTH      = 5,
    parameter int TIMEOUT         = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [1:0]                 req_op_i,
    input  logic [ADDR_WIDTH-1:0]      req_src_i,
    input  logic [ADDR_WIDTH-1:0]      req_dst_i,
    output logic                       rd_en_o,
    output logic [ADDR_WIDTH-1:0]      rd_addr_o,
    input  logic [DWIDTH_PER_EXEC-1:0] rd_data_i,
    output logic                       red_start_o,
    output logic                       red_sum_o,
    output logic                       red_max_o,
    output logic [DWIDTH_PER_EXEC-1:0] red_operand_o,
    input  logic                       red_done_i,
    input  logic [OPERAND_WIDTH-1:0]   red_dout_i,
    output logic                       wb_valid_o,
    input  logic                       wb_ready_i,
    output logic [ADDR_WIDTH-1:0]      wb_addr_o,
    output logic [OPERAND_WIDTH-1:0]   wb_data_o,
    output logic                       busy_o,
    output logic                       err_o
);

    localparam int CW = (EXEC_CNT > 1) ? $clog2(EXEC_CNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(EXEC_CNT - 1);
    localparam logic [7:0] TMO = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, READ, CAPT, ISSUE, WAIT, WB
    } state_t;

    state_t                     state_q, state_d;
    logic [CW-1:0]              chunk_q, chunk_d;
    logic [1:0]                 op_q, op_d;
    logic [ADDR_WIDTH-1:0]      src_q, src_d;
    logic [ADDR_WIDTH-1:0]      dst_q, dst_d;
    logic [7:0]                 tmo_q, tmo_d;
    logic [DWIDTH_PER_EXEC-1:0] operand_q, operand_d;
    logic [OPERAND_WIDTH-1:0]   result_q, result_d;
    logic                       err_d;

    // Registered outputs, all derived from the next-state values.
    logic                       req_ready_q, busy_q, rd_en_q, err_q;
    logic                       red_start_q, red_sum_q, red_max_q;
    logic                       wb_valid_q;
    logic [ADDR_WIDTH-1:0]      rd_addr_q, wb_addr_q;
    logic [OPERAND_WIDTH-1:0]   wb_data_q;

    always_comb begin
        state_d   = state_q;
        chunk_d   = chunk_q;
        op_d      = op_q;
        src_d     = src_q;
        dst_d     = dst_q;
        tmo_d     = tmo_q;
        operand_d = operand_q;
        result_d  = result_q;
        err_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    op_d    = req_op_i;
                    src_d   = req_src_i;
                    dst_d   = req_dst_i;
                    chunk_d = '0;
                    // Only 01 and 10 are legal op selects.
                    if (req_op_i[0] ^ req_op_i[1]) begin
                        state_d = READ;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            READ: state_d = CAPT;
            CAPT: begin
                operand_d = rd_data_i;
                state_d   = ISSUE;
            end
            ISSUE: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                tmo_d = tmo_q + 8'd1;
                if (red_done_i) begin
                    if (chunk_q == LAST) begin
                        result_d = red_dout_i;
                        state_d  = WB;
                    end else begin
                        chunk_d = chunk_q + CW'(1);
                        state_d = READ;
                    end
                end else if (tmo_d == TMO) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            WB: begin
                if (wb_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            chunk_q     <= '0;
            op_q        <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            tmo_q       <= '0;
            operand_q   <= '0;
            result_q    <= '0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            red_start_q <= 1'b0;
            red_sum_q   <= 1'b0;
            red_max_q   <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            chunk_q     <= chunk_d;
            op_q        <= op_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            tmo_q       <= tmo_d;
            operand_q   <= operand_d;
            result_q    <= result_d;
            req_ready_q <= (state_d == IDLE);
            busy_q      <= (state_d != IDLE);
            rd_en_q     <= (state_d == READ);
            // Address wraps modulo 2^ADDR_WIDTH by construction.
            rd_addr_q   <= (state_d == READ) ?
                           src_d + ADDR_WIDTH'(chunk_d) : '0;
            red_start_q <= (state_d == ISSUE);
            red_sum_q   <= (state_d != IDLE) & op_d[0];
            red_max_q   <= (state_d != IDLE) & op_d[1];
            wb_valid_q  <= (state_d == WB);
            wb_addr_q   <= (state_d == WB) ? dst_d : '0;
            wb_data_q   <= (state_d == WB) ? result_d : '0;
            err_q       <= err_d;
        end
    end

    assign req_ready_o   = req_ready_q;
    assign busy_o        = busy_q;
    assign rd_en_o       = rd_en_q;
    assign rd_addr_o     = rd_addr_q;
    assign red_start_o   = red_start_q;
    assign red_sum_o     = red_sum_q;
    assign red_max_o     = red_max_q;
    assign red_operand_o = operand_q;
    assign wb_valid_o    = wb_valid_q;
    assign wb_addr_o     = wb_addr_q;
    assign wb_data_o     = wb_data_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_vpu_reduction_seq.sv
// tb_vpu_reduction_seq: directed bench for vpu_reduction_seq with a
// VRF model and a behavioural fp16 reduction unit model (latency 5).
module tb_vpu_reduction_seq;

    logic         clk;
    logic         rst;
    logic         req_valid_i;
    logic         req_ready_o;
    logic [1:0]   req_op_i;
    logic [4:0]   req_src_i;
    logic [4:0]   req_dst_i;
    logic         rd_en_o;
    logic [4:0]   rd_addr_o;
    logic [511:0] rd_data_i;
    logic         red_start_o;
    logic         red_sum_o;
    logic         red_max_o;
    logic [511:0] red_operand_o;
    logic         red_done_i;
    logic [15:0]  red_dout_i;
    logic         wb_valid_o;
    logic         wb_ready_i;
    logic [4:0]   wb_addr_o;
    logic [15:0]  wb_data_o;
    logic         busy_o;
    logic         err_o;

    vpu_reduction_seq dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_op_i      (req_op_i),
        .req_src_i     (req_src_i),
        .req_dst_i     (req_dst_i),
        .rd_en_o       (rd_en_o),
        .rd_addr_o     (rd_addr_o),
        .rd_data_i     (rd_data_i),
        .red_start_o   (red_start_o),
        .red_sum_o     (red_sum_o),
        .red_max_o     (red_max_o),
        .red_operand_o (red_operand_o),
        .red_done_i    (red_done_i),
        .red_dout_i    (red_dout_i),
        .wb_valid_o    (wb_valid_o),
        .wb_ready_i    (wb_ready_i),
        .wb_addr_o     (wb_addr_o),
        .wb_data_o     (wb_data_o),
        .busy_o        (busy_o),
        .err_o         (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  src;
        logic [4:0]  dst;
        int          pat;
        logic [15:0] exp_data;
        bit          exp_err;
    } vec_t;

    vec_t         vecs[6];
    logic [511:0] mem[32];
    logic [4:0]   rd_log[$];
    int  n_pass = 0, n_total = 0;
    int  n_start = 0, n_wb = 0, n_err = 0, n_busy = 0, n_opbad = 0;
    int  cyc = 0, last_start_cyc = 0, last_err_cyc = 0;
    logic [4:0]  last_addr;
    logic [15:0] last_data;
    logic [1:0]  expect_op;
    bit  hang;
    real acc;
    int  nst = 0, cnt = 0;

    function automatic logic [15:0] to_fp16(input real r);
        int  e = 0;
        real m = r;
        int  man;
        if (r <= 0.0) return 16'h0000;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0) begin m = m * 2.0; e--; end
        man = int'((m - 1.0) * 1024.0);
        return {1'b0, 5'(e + 15), 10'(man)};
    endfunction

    function automatic real from_fp16(input logic [15:0] h);
        real v;
        int  e;
        if (h[14:10] == 5'd0) return 0.0;
        v = 1.0 + real'(h[9:0]) / 1024.0;
        e = int'(h[14:10]) - 15;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return h[15] ? -v : v;
    endfunction

    // VRF model: data valid exactly one cycle after rd_en_o.
    always @(posedge clk) begin
        if (rd_en_o) rd_data_i <= mem[rd_addr_o];
        else         rd_data_i <= '1;
    end

    // Reduction unit model: accumulates over the op, done L=5 after start.
    always @(posedge clk) begin
        red_done_i <= 1'b0;
        if (!busy_o) begin
            acc = 0.0;
            nst = 0;
            cnt = 0;
        end else if (red_start_o) begin
            for (int e = 0; e < 32; e++) begin
                real x;
                x = from_fp16(red_operand_o[e*16 +: 16]);
                if (red_sum_o) acc = acc + x;
                else if (x > acc) acc = x;
            end
            if (!(hang && nst >= 1)) cnt = 5;
            nst++;
        end
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                red_done_i <= 1'b1;
                red_dout_i <= to_fp16(acc);
            end
        end
    end

    always @(posedge clk) begin
        if (rd_en_o) rd_log.push_back(rd_addr_o);
        if (red_start_o) begin
            n_start++;
            last_start_cyc = cyc;
        end
        if (wb_valid_o && wb_ready_i) begin
            n_wb++;
            last_addr = wb_addr_o;
            last_data = wb_data_o;
        end
        if (err_o) begin
            n_err++;
            last_err_cyc = cyc;
        end
        if (busy_o) n_busy++;
        if (busy_o ? ({red_max_o, red_sum_o} != expect_op)
                   : (red_max_o | red_sum_o)) n_opbad++;
        cyc++;
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic check_idle_reset(input string nm);
        check({nm, "_ctl"}, 32'({req_ready_o, busy_o, rd_en_o, red_start_o,
              red_sum_o, red_max_o, wb_valid_o, err_o}), 32'h80);
        check({nm, "_dat"}, 32'(|{rd_addr_o, wb_addr_o, wb_data_o,
              red_operand_o}), 0);
    endtask

    task automatic load_mem(input logic [4:0] src, input int pat);
        for (int a = 0; a < 32; a++) mem[a] = {32{16'h4C00}};
        for (int c = 0; c < 4; c++) begin
            logic [511:0] ch;
            ch = '0;
            for (int e = 0; e < 32; e++) begin
                logic [15:0] h;
                if (pat == 0) h = 16'h3C00;
                else h = to_fp16(real'(e % 8 + 1));
                if (pat == 1 && c == 2 && e == 5) h = 16'h4B00;
                ch[e*16 +: 16] = h;
            end
            mem[5'(32'(src) + c)] = ch;
        end
    endtask

    task automatic launch(input logic [1:0] op, input logic [4:0] src,
                          input logic [4:0] dst);
        int n = 0;
        @(negedge clk);
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_src_i   = src;
        req_dst_i   = dst;
        while (!req_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept", 32'(req_ready_o), 1);
        @(posedge clk);
        #1 req_valid_i = 1'b0;
    endtask

    task automatic wait_done(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!wb_valid_o && !err_o && k < 1000);
        check("done_bound", 32'(k < 1000), 1);
    endtask

    task automatic do_vector(input vec_t v);
        int k;
        int s0, w0, e0, b0, x0;
        load_mem(v.src, v.pat);
        rd_log.delete();
        s0 = n_start; w0 = n_wb; e0 = n_err; b0 = n_busy; x0 = n_opbad;
        expect_op = v.op;
        launch(v.op, v.src, v.dst);
        wait_done(k);
        repeat (2) @(negedge clk);
        if (v.exp_err) begin
            check("err_lat", k, 1);
            check("err_cnt", n_err - e0, 1);
            check("err_rd", rd_log.size(), 0);
            check("err_start", n_start - s0, 0);
            check("err_busy", n_busy - b0, 0);
            check("err_wb", n_wb - w0, 0);
        end else begin
            check("lat", k, 33);
            check("wb_data", 32'(last_data), 32'(v.exp_data));
            check("wb_addr", 32'(last_addr), 32'(v.dst));
            check("wb_cnt", n_wb - w0, 1);
            check("starts", n_start - s0, 4);
            check("rd_cnt", rd_log.size(), 4);
            for (int c = 0; c < rd_log.size(); c++)
                check("rd_addr", 32'(rd_log[c]), 32'(5'(32'(v.src) + c)));
            check("op_sel", n_opbad - x0, 0);
            check("no_err", n_err - e0, 0);
            check("back_idle", 32'({req_ready_o, busy_o}), 32'b10);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, n, bad, s0, w0, e0;
        logic [4:0]  a;
        logic [15:0] d;
        vecs[0] = '{2'b01, 5'd4,  5'd9,  0, 16'h5800, 1'b0};
        vecs[1] = '{2'b10, 5'd12, 5'd3,  1, 16'h4B00, 1'b0};
        vecs[2] = '{2'b11, 5'd0,  5'd0,  0, 16'h0000, 1'b1};
        vecs[3] = '{2'b00, 5'd7,  5'd2,  0, 16'h0000, 1'b1};
        vecs[4] = '{2'b10, 5'd20, 5'd31, 0, 16'h3C00, 1'b0};
        vecs[5] = '{2'b01, 5'd30, 5'd1,  0, 16'h5800, 1'b0};
        rst = 1'b1; req_valid_i = 1'b0; req_op_i = '0;
        req_src_i = '0; req_dst_i = '0; wb_ready_i = 1'b1;
        hang = 1'b0; expect_op = '0;
        load_mem(5'd0, 0);
        repeat (3) @(negedge clk);
        check_idle_reset("rst_hold");
        rst = 1'b0;
        @(negedge clk);
        check_idle_reset("rst_after");

        foreach (vecs[i]) do_vector(vecs[i]);

        // Write-back backpressure with a competing request.
        load_mem(5'd4, 0);
        expect_op = 2'b01;
        wb_ready_i = 1'b0;
        w0 = n_wb;
        launch(2'b01, 5'd4, 5'd9);
        wait_done(k);
        a = wb_addr_o;
        d = wb_data_o;
        check("bp_data", 32'(d), 32'h5800);
        check("bp_addr", 32'(a), 9);
        req_valid_i = 1'b1;
        req_dst_i = 5'd2;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            if (!wb_valid_o || wb_addr_o != a || wb_data_o != d ||
                req_ready_o) bad++;
        end
        check("bp_stable", bad, 0);
        wb_ready_i = 1'b1;
        @(negedge clk);
        check("bp_hs", n_wb - w0, 1);
        check("bp_ready", 32'({req_ready_o, busy_o}), 32'b10);
        @(negedge clk);
        check("bp_accept", 32'({busy_o, rd_en_o}), 32'b11);
        req_valid_i = 1'b0;
        wait_done(k);
        check("bp_lat2", k, 32);
        repeat (2) @(negedge clk);
        check("bp_wb2", n_wb - w0, 2);
        check("bp_addr2", 32'(last_addr), 2);

        // Unit never answers chunk 1: timeout abort, then recovery.
        hang = 1'b1;
        s0 = n_start; w0 = n_wb; e0 = n_err;
        launch(2'b01, 5'd4, 5'd9);
        wait_done(k);
        check("tmo_err", 32'(err_o), 1);
        repeat (3) @(negedge clk);
        check("tmo_gap", last_err_cyc - last_start_cyc, 256);
        check("tmo_starts", n_start - s0, 2);
        check("tmo_wb", n_wb - w0, 0);
        check("tmo_errcnt", n_err - e0, 1);
        check("tmo_idle", 32'({req_ready_o, busy_o}), 32'b10);
        hang = 1'b0;
        do_vector(vecs[0]);

        // Reset during WAIT of chunk 2, with a wrapping source address.
        load_mem(5'd30, 0);
        expect_op = 2'b01;
        s0 = n_start; w0 = n_wb; e0 = n_err;
        launch(2'b01, 5'd30, 5'd5);
        n = 0;
        while (n_start - s0 < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst_reach", n_start - s0, 3);
        rst = 1'b1;
        @(negedge clk);
        check_idle_reset("rst_mid");
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("rst_nowb", n_wb - w0, 0);
        check("rst_noerr", n_err - e0, 0);
        do_vector(vecs[5]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vpu_reduction_seq.md
Name: vpu_reduction_seq

Overview:
Sequencer that runs one full-vector reduction (FP sum or FP max) on the VPU reduction unit. It accepts a request, reads EXEC_CNT operand chunks from the vector register file, and issues each chunk with a one-cycle start pulse. It counts the unit's per-chunk done pulses and writes the final scalar back to the register file over a valid/ready handshake. It sits between the VPU issue logic and one reduction unit instance and holds the unit's op select stable for the whole operation.

Parameters:
EXEC_CNT, 4, chunks per vector (power of two, >=2)
DWIDTH_PER_EXEC, 512, chunk width in bits
OPERAND_WIDTH, 16, scalar element width
ADDR_WIDTH, 5, register file address width
TIMEOUT, 255, max cycles in WAIT before abort (8-bit counter)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready
req_op_i  in  2  bit0 = fp_sum, bit1 = fp_max; must be one-hot
req_src_i  in  ADDR_WIDTH  base address of chunk 0
req_dst_i  in  ADDR_WIDTH  result write address
rd_en_o  out  1  register file read strobe
rd_addr_o  out  ADDR_WIDTH  read address
rd_data_i  in  DWIDTH_PER_EXEC  read data, valid exactly 1 cycle after rd_en_o
red_start_o  out  1  start pulse to reduction unit
red_sum_o  out  1  fp_sum select, held for whole op
red_max_o  out  1  fp_max select, held for whole op
red_operand_o  out  DWIDTH_PER_EXEC  registered chunk operand
red_done_i  in  1  reduction unit done pulse
red_dout_i  in  OPERAND_WIDTH  reduction result (element 0 of unit output)
wb_valid_o  out  1  write-back valid
wb_ready_i  in  1  write-back ready
wb_addr_o  out  ADDR_WIDTH  write-back address
wb_data_o  out  OPERAND_WIDTH  write-back data
busy_o  out  1  high whenever state != IDLE
err_o  out  1  one-cycle error pulse (illegal op or timeout)

Behaviour:
- The block has one clock, clk. Reset rst is synchronous and active-high.
- While rst is high, or in the cycle after it: state=IDLE, chunk=0. All outputs are 0 except req_ready_o=1. Operand, result and address registers are cleared. Reset mid-operation abandons the operation; no write-back occurs.
- FSM states: IDLE, READ, CAPT, ISSUE, WAIT, WB.
- IDLE: req_ready_o=1. On req_valid_i:
  - Latch op, src and dst, and set chunk=0.
  - If req_op_i is not one-hot (00 or 11): pulse err_o next cycle and stay in IDLE.
  - Otherwise go to READ.
- READ: rd_en_o=1 and rd_addr_o=src+chunk (modulo 2^ADDR_WIDTH; wrap is permitted, not flagged). Next state is CAPT.
- CAPT: red_operand_o register <= rd_data_i. Next state is ISSUE.
- ISSUE: red_start_o=1 for exactly one cycle. The timeout counter clears. Next state is WAIT.
- WAIT: the timeout counter increments each cycle.
  - On red_done_i with chunk<EXEC_CNT-1: chunk+=1, go to READ.
  - On red_done_i with chunk==EXEC_CNT-1: result <= red_dout_i, go to WB.
  - If the counter reaches TIMEOUT without done: pulse err_o, go to IDLE, no write-back.
  - red_done_i seen in any state other than WAIT is ignored.
- WB: wb_valid_o=1, wb_addr_o=dst, wb_data_o=result. These are held stable until wb_ready_i. On wb_ready_i go to IDLE, so req_ready_o=1 the next cycle.
- red_sum_o/red_max_o equal the latched op from leaving IDLE until returning to IDLE, and are 0 in IDLE. red_operand_o holds its value between captures.
- Latency: each chunk takes 3 cycles plus the unit latency L. The total from accept to first wb_valid_o is EXEC_CNT*(3+L)+1 cycles with L measured ISSUE to done.
- Only one operation is in flight. There is no request queue.
- Simultaneous req_valid_i and busy: the request is not accepted, because ready=0.

Test Plan:
- Sum, EXEC_CNT=4, OPERAND_WIDTH=16, src=4, dst=9, all elements fp16 1.0 (0x3C00), unit model L=5 -> reads at addrs 4,5,6,7; four start pulses; exactly one write-back with addr 9, data 0x5800 (128.0); accept-to-wb_valid = 33 cycles.
- Max, elements = index-valued fp16 with one 0x4B00 (14.0) in chunk 2, all others smaller -> one wb with data 0x4B00; red_max_o=1 and red_sum_o=0 for the whole op.
- req_op_i=2'b11 -> accepted (ready=1 that cycle), err_o pulses one cycle, no rd_en_o, no red_start_o, busy_o stays 0.
- Unit model never asserts done after chunk 1 issue, TIMEOUT=255 -> err_o pulses 256 cycles after ISSUE; back in IDLE; no wb_valid_o; next request completes normally.
- wb_ready_i held 0 for 10 cycles -> wb_valid_o, addr and data stable for all 10 cycles; a req_valid_i raised meanwhile is not accepted until the cycle after the handshake.
- rst asserted during WAIT of chunk 2, plus src=30 with wrap -> all outputs 0 and req_ready_o=1 next cycle; a new request with src=30 reads addrs 30,31,0,1.
